// File: rtl/lcd_text_frame.sv
// Character-frame source for the 16x2 text LCD: rotating message on line 1 and a press counter on line 2.
// Reads come from per-frame snapshot registers, so each frame the sequencer fetches is internally consistent.
module lcd_text_frame #(
    parameter int SHIFT_TICKS = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       btn,
    input  logic       frame_req,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_ack,
    output logic [3:0] press_cnt
);

    localparam int TW = (SHIFT_TICKS > 2) ? $clog2(SHIFT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SHIFT_TICKS - 1);

    logic [TW-1:0] r_tick_cnt;
    logic [3:0]    r_rot_ptr;
    logic          r_btn_d;
    logic [3:0]    r_digit;
    logic [3:0]    r_snap_rot;
    logic [3:0]    r_snap_digit;
    logic [7:0]    r_rd_data;
    logic          r_frame_ack;

    logic          w_tick_wrap;
    logic          w_press;
    logic [3:0]    w_rom_idx;
    logic [7:0]    w_rom_char;
    logic [7:0]    w_line2_char;
    logic [7:0]    w_char;

    assign w_tick_wrap = (r_tick_cnt == TICK_LAST);
    assign w_press     = btn & ~r_btn_d;
    assign w_rom_idx   = rd_addr[3:0] + r_snap_rot;

    // Rotation timebase: rot_ptr advances on the cycle the tick counter wraps.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_tick_cnt <= '0;
            r_rot_ptr  <= 4'd0;
        end else if (w_tick_wrap) begin
            r_tick_cnt <= '0;
            r_rot_ptr  <= r_rot_ptr + 4'd1;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_btn_d <= 1'b0;
            r_digit <= 4'd0;
        end else begin
            r_btn_d <= btn;
            if (w_press) begin
                r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
            end
        end
    end

    // Snapshot samples the pre-update live values when a step or press lands on the same edge.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_snap_rot   <= 4'd0;
            r_snap_digit <= 4'd0;
            r_frame_ack  <= 1'b0;
        end else begin
            r_frame_ack <= frame_req;
            if (frame_req) begin
                r_snap_rot   <= r_rot_ptr;
                r_snap_digit <= r_digit;
            end
        end
    end

    always_comb begin
        w_rom_char = 8'h20;
        case (w_rom_idx)
            4'd0:    w_rom_char = 8'h52;
            4'd1:    w_rom_char = 8'h4F;
            4'd2:    w_rom_char = 8'h54;
            4'd3:    w_rom_char = 8'h41;
            4'd4:    w_rom_char = 8'h54;
            4'd5:    w_rom_char = 8'h49;
            4'd6:    w_rom_char = 8'h4E;
            4'd7:    w_rom_char = 8'h47;
            4'd8:    w_rom_char = 8'h2E;
            4'd9:    w_rom_char = 8'h2E;
            4'd10:   w_rom_char = 8'h2E;
            default: w_rom_char = 8'h20;
        endcase
    end

    always_comb begin
        w_line2_char = 8'h20;
        case (rd_addr[3:0])
            4'd0:    w_line2_char = 8'h50;
            4'd1:    w_line2_char = 8'h52;
            4'd2:    w_line2_char = 8'h45;
            4'd3:    w_line2_char = 8'h53;
            4'd4:    w_line2_char = 8'h53;
            4'd5:    w_line2_char = 8'h20;
            4'd6:    w_line2_char = {4'h3, r_snap_digit};
            default: w_line2_char = 8'h20;
        endcase
    end

    assign w_char = rd_addr[4] ? w_line2_char : w_rom_char;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_rd_data <= 8'h20;
        end else begin
            r_rd_data <= w_char;
        end
    end

    assign rd_data   = r_rd_data;
    assign frame_ack = r_frame_ack;
    assign press_cnt = r_digit;

endmodule

// File: tb/tb_lcd_text_frame.sv
// Bench for lcd_text_frame: reference model plus expected-character queue, with directed image checks.
module tb_lcd_text_frame;

    localparam int SHIFT = 4;

    logic       clk;
    logic       resetn;
    logic       btn;
    logic       frame_req;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_ack;
    logic [3:0] press_cnt;
    logic       rd_en;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    logic [7:0] rom   [16] = '{8'h52, 8'h4F, 8'h54, 8'h41, 8'h54, 8'h49, 8'h4E, 8'h47,
                               8'h2E, 8'h2E, 8'h2E, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
    logic [7:0] line2 [16] = '{8'h50, 8'h52, 8'h45, 8'h53, 8'h53, 8'h20, 8'h30, 8'h20,
                               8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};

    // reference model state
    int         m_tick;
    logic [3:0] m_rot;
    logic       m_btn_d;
    logic [3:0] m_digit;
    logic [3:0] m_snap_rot;
    logic [3:0] m_snap_digit;
    logic       m_ack;
    logic       m_pend;

    lcd_text_frame #(.SHIFT_TICKS(SHIFT)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .btn       (btn),
        .frame_req (frame_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .frame_ack (frame_ack),
        .press_cnt (press_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] img_char(input logic [4:0] a, input logic [3:0] r,
                                            input logic [3:0] d);
        logic [3:0] idx;
        logic [7:0] c;
        idx = a[3:0] + r;
        if (!a[4]) begin
            c = rom[idx];
        end else if (a[3:0] == 4'd6) begin
            c = 8'h30 + {4'h0, d};
        end else begin
            c = line2[a[3:0]];
        end
        return c;
    endfunction

    always @(posedge clk or posedge resetn) begin
        if (resetn) begin
            m_tick = 0; m_rot = 0; m_btn_d = 0; m_digit = 0;
            m_snap_rot = 0; m_snap_digit = 0; m_ack = 0; m_pend = 0;
            exp_q.delete();
        end else begin
            if (rd_en) exp_q.push_back(img_char(rd_addr, m_snap_rot, m_snap_digit));
            m_pend = rd_en;
            m_ack  = frame_req;
            if (frame_req) begin
                m_snap_rot   = m_rot;
                m_snap_digit = m_digit;
            end
            if (btn && !m_btn_d) m_digit = (m_digit == 4'd9) ? 4'd0 : m_digit + 4'd1;
            m_btn_d = btn;
            if (m_tick == SHIFT - 1) begin
                m_tick = 0;
                m_rot  = m_rot + 4'd1;
            end else begin
                m_tick++;
            end
        end
    end

    // scoreboard: compare on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!resetn) begin
            if (m_pend) begin
                if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                else chk("rd_data", rd_data, exp_q.pop_front());
            end
            chk("frame_ack", frame_ack, m_ack);
            chk("press_cnt", press_cnt, m_digit);
        end
    end

    // driver tasks (called at a falling edge, return at a falling edge)
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        btn = 0; frame_req = 0; rd_en = 0; rd_addr = 0;
        tick(3);
        resetn = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
    endtask

    task automatic press();
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_one(input logic [4:0] a, input logic [7:0] exp, input string tag);
        rd_addr = a;
        rd_en   = 1'b1;
        @(negedge clk);
        rd_en   = 1'b0;
        chk(tag, rd_data, exp);
    endtask

    task automatic sweep_reset_image(input string tag);
        for (int a = 0; a < 32; a++) begin
            read_one(5'(a), (a < 16) ? rom[a] : line2[a-16], tag);
        end
    endtask

    initial begin
        resetn = 1'b1;
        btn = 0; frame_req = 0; rd_en = 0; rd_addr = 0;
        #1;
        chk("reset_rd_data", rd_data, 8'h20);
        chk("reset_ack", frame_ack, 0);
        chk("reset_press", press_cnt, 0);
        tick(2);
        resetn = 1'b0;

        // post-reset image, back-to-back sweep
        pulse_frame();
        chk("ack_pulse", frame_ack, 1);
        sweep_reset_image("img_reset");
        chk("ack_once", frame_ack, 0);

        // rotation step and wrap
        do_reset();
        tick(4);
        pulse_frame();
        read_one(5'd0, 8'h4F, "rot1_a0");
        read_one(5'd15, 8'h52, "rot1_a15");
        do_reset();
        tick(64);
        pulse_frame();
        read_one(5'd0, 8'h52, "rot_wrap_a0");

        // presses
        do_reset();
        repeat (3) press();
        read_one(5'd22, 8'h30, "digit_stale");
        chk("press3", press_cnt, 4'd3);
        pulse_frame();
        read_one(5'd22, 8'h33, "digit_new");
        repeat (7) press();
        chk("press_wrap", press_cnt, 4'd0);
        btn = 1'b1;
        tick(50);
        btn = 1'b0;
        tick(1);
        chk("press_held", press_cnt, 4'd1);

        // frame_req coinciding with the rotation step
        do_reset();
        tick(3);
        pulse_frame();
        read_one(5'd0, 8'h52, "coinc_old");
        pulse_frame();
        read_one(5'd0, 8'h4F, "coinc_new");

        // reset mid-sweep with rot=5, digit=7, and a frame_req in flight
        do_reset();
        repeat (7) press();
        tick(7);
        pulse_frame();
        read_one(5'd0, 8'h49, "pre_rst_a0");
        read_one(5'd22, 8'h37, "pre_rst_a22");
        rd_addr = 5'd1;
        frame_req = 1'b1;
        @(posedge clk);
        #2;
        frame_req = 1'b0;
        resetn = 1'b1;
        #1;
        chk("midrst_rd_data", rd_data, 8'h20);
        chk("midrst_press", press_cnt, 0);
        chk("midrst_ack", frame_ack, 0);
        tick(2);
        resetn = 1'b0;
        tick(1);
        chk("no_lost_ack", frame_ack, 0);
        pulse_frame();
        sweep_reset_image("img_after_rst");

        // consecutive frame_req pulses
        frame_req = 1'b1;
        tick(3);
        frame_req = 1'b0;
        tick(1);

        // random traffic, checked by the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) btn = ~btn;
            frame_req = ($urandom_range(0, 7) == 0);
            rd_addr   = 5'($urandom_range(0, 31));
            rd_en     = 1'b1;
            @(negedge clk);
        end
        rd_en = 0; frame_req = 0; btn = 0;
        tick(2);
        chk("sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_text_frame.md
# lcd_text_frame

Character-frame source that sits directly upstream of the 16x2 text-LCD write sequencer. It holds the 32-character display image: line 1 is the message "ROTATING...     " rotating left, and line 2 is "PRESS n", where n counts button presses. The LCD sequencer requests a consistent snapshot at the start of each frame, then reads characters by address with 1-cycle latency.

## Interface
Parameters:
- SHIFT_TICKS, 100, clk cycles between line-1 rotation steps (legal range >= 2)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-high
- btn  in  1  push-button level, already synchronous to clk
- frame_req  in  1  one-cycle pulse from the LCD sequencer: snapshot live state for a new frame
- rd_addr  in  5  character address; 0-15 = line 1 col 0-15, 16-31 = line 2 col 0-15
- rd_data  out  8  ASCII code for rd_addr, registered
- frame_ack  out  1  one-cycle pulse: snapshot taken, rd_data now reflects the new frame
- press_cnt  out  4  live BCD press count, 0-9

## Operation
- Message ROM, 16 entries: R O T A T I N G . . . followed by 5 spaces.
  - Codes: 0x52 0x4F 0x54 0x41 0x54 0x49 0x4E 0x47 0x2E 0x2E 0x2E, then 0x20 x5.
- Tick counter tick_cnt counts 0..SHIFT_TICKS-1.
  - At SHIFT_TICKS-1 it wraps to 0 and rot_ptr increments.
  - rot_ptr is 4 bits, 0..15, and wraps 15->0.
- Button edge detect:
  - btn_d is btn registered.
  - A press is btn=1 and btn_d=0.
  - A held button counts once.
- Press counter: BCD digit increments on each press and wraps 9->0. press_cnt is the live digit.
- Snapshot registers snap_rot (4 bits) and snap_digit (4 bits) load rot_ptr and the digit on frame_req.
  - They change only on frame_req.
  - All reads use snapshot values only, so every frame is internally consistent.
- Character mapping, using snapshot values:
  - addr 0-15: ROM[(addr + snap_rot) mod 16]
  - addr 16-21: "PRESS " = 0x50 0x52 0x45 0x53 0x53 0x20
  - addr 22: 0x30 + snap_digit
  - addr 23-31: 0x20
- frame_ack = frame_req delayed one cycle.
- Reset values:
  - tick_cnt=0, rot_ptr=0, btn_d=0, digit=0
  - snap_rot=0, snap_digit=0
  - rd_data=0x20, frame_ack=0, press_cnt=0

## Timing
- Read latency is 1 cycle: rd_data at edge n+1 reflects rd_addr sampled at edge n.
- rd_addr may change every cycle, so back-to-back reads run at full rate.
- Snapshot latency: frame_req sampled at edge n loads the snapshot at edge n.
  - A read with rd_addr presented in cycle n+1 returns new-frame data at edge n+2.
  - frame_ack is high during cycle n+1 to n+2.
- Simultaneous frame_req and rotation step: snapshot takes the pre-increment rot_ptr.
  - The new value appears only at the next frame_req.
- Simultaneous frame_req and button press: snapshot takes the pre-increment digit.
- frame_req on consecutive cycles: each one reloads the snapshot and each one yields a frame_ack pulse.
- Reset asserted mid-frame:
  - All registers clear asynchronously and immediately.
  - rd_data reads 0x20 until the first edge after release.
  - A frame_req in flight is lost, and no frame_ack is issued.
- After reset release, the first rotation occurs SHIFT_TICKS edges later.

## Test plan
- Reset, pulse frame_req, sweep addr 0-31 -> line 1 reads 0x52,0x4F,...,0x2E then 0x20 x5; addr 16-22 read 0x50 0x52 0x45 0x53 0x53 0x20 0x30; addr 23-31 read 0x20; frame_ack pulses once, 1 cycle after frame_req.
- SHIFT_TICKS=4: wait 4 cycles, then frame_req, read addr 0 -> 0x4F and addr 15 -> 0x52. After 64 cycles from reset plus a frame_req, addr 0 -> 0x52 (rot_ptr wrap).
- 3 distinct presses, no frame_req -> addr 22 still reads 0x30 and press_cnt=3. Then frame_req -> addr 22 reads 0x33. 10 presses total -> press_cnt=0. Button held 50 cycles -> counted once.
- frame_req on the same edge as the rotation step (tick_cnt=SHIFT_TICKS-1) -> addr 0 reads the old character. The next frame_req -> the rotated character.
- Reset pulsed mid-sweep with rot_ptr=5 and digit=7 -> rd_data=0x20 and press_cnt=0 immediately. The first frame after release matches the post-reset image.
- Addresses 0..31 presented back-to-back -> rd_data matches the expected image with exactly 1-cycle lag, with no bubbles.
